// File: rtl/display_scroll_sequencer.sv
// Scroll scheduler for the four-digit seven-segment driver.
// Holds a MSG_LEN-char message and shows a 4-char window of it on char3..char0.
// While running, the window advances one char every TICK_DIV clocks.
module display_scroll_sequencer #(
    parameter int   MSG_LEN  = 16,
    parameter int   TICK_DIV = 5000000,
    parameter int   CHAR_W   = 4,
    localparam int  AW       = $clog2(MSG_LEN)
) (
    input  logic              clk,
    input  logic              reset_sync,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic [AW-1:0]     pos,
    output logic              step_done,
    output logic              wrap,
    output logic [CHAR_W-1:0] char3,
    output logic [CHAR_W-1:0] char2,
    output logic [CHAR_W-1:0] char1,
    output logic [CHAR_W-1:0] char0
);

    localparam int            CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [AW-1:0] POS_LAST = AW'(MSG_LEN - 1);
    // One extra bit so that pos+3 and MSG_LEN itself are representable.
    localparam logic [AW:0]   LEN      = (AW + 1)'(MSG_LEN);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_reg, state_next;
    logic [AW-1:0]     pos_reg, pos_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              busy_reg;
    logic              step_reg, step_next;
    logic              wrap_reg, wrap_next;
    logic [CHAR_W-1:0] buf_reg [MSG_LEN];
    logic [CHAR_W-1:0] win_reg [4];
    logic [CHAR_W-1:0] win_rd  [4];
    logic              wr_ok;

    // Out-of-range addresses match no entry and are silently dropped.
    assign wr_ok = wr_en && ({1'b0, wr_addr} < LEN);

    // Window read addresses: pos+k folded back by one subtraction, so any
    // MSG_LEN works, not only powers of two.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_win
            logic [AW:0] sum;
            logic [AW:0] idx;
            assign sum        = {1'b0, pos_reg} + (AW + 1)'(gi);
            assign idx        = (sum >= LEN) ? (sum - LEN) : sum;
            assign win_rd[gi] = buf_reg[idx[AW-1:0]];
        end
    endgenerate

    // Next-state, position, tick counter and pulse decode.
    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        cnt_next   = cnt_reg;
        step_next  = 1'b0;
        wrap_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !stop) begin
                    state_next = RUN;
                    pos_next   = '0;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    // stop has priority over a simultaneous start
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (start) begin
                    pos_next = '0;
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_next  = '0;
                    step_next = 1'b1;
                    if (pos_reg == POS_LAST) begin
                        pos_next  = '0;
                        wrap_next = 1'b1;
                    end else begin
                        pos_next = pos_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control registers; busy mirrors the state being entered.
    always_ff @(posedge clk or posedge reset_sync) begin
        if (reset_sync) begin
            state_reg <= IDLE;
            pos_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            step_reg  <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pos_reg   <= pos_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= (state_next == RUN);
            step_reg  <= step_next;
            wrap_reg  <= wrap_next;
        end
    end

    // Message buffer; cleared by reset, so it lives in flops rather than RAM.
    always_ff @(posedge clk or posedge reset_sync) begin
        if (reset_sync) begin
            for (int i = 0; i < MSG_LEN; i++) buf_reg[i] <= '0;
        end else if (wr_ok) begin
            buf_reg[wr_addr] <= wr_data;
        end
    end

    // Window registers sample the buffer at the current pos every cycle.
    always_ff @(posedge clk or posedge reset_sync) begin
        if (reset_sync) begin
            for (int i = 0; i < 4; i++) win_reg[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) win_reg[i] <= win_rd[i];
        end
    end

    assign busy      = busy_reg;
    assign pos       = pos_reg;
    assign step_done = step_reg;
    assign wrap      = wrap_reg;
    assign char3     = win_reg[0];
    assign char2     = win_reg[1];
    assign char1     = win_reg[2];
    assign char0     = win_reg[3];

endmodule

// File: tb/tb_display_scroll_sequencer.sv
// Directed bench for display_scroll_sequencer with MSG_LEN=6, TICK_DIV=4.
module tb_display_scroll_sequencer;

    localparam int MSG_LEN  = 6;
    localparam int TICK_DIV = 4;
    localparam int CHAR_W   = 4;
    localparam int AW       = 3;

    logic              clk;
    logic              reset_sync;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [CHAR_W-1:0] wr_data;
    logic              start;
    logic              stop;
    logic              busy;
    logic [AW-1:0]     pos;
    logic              step_done;
    logic              wrap;
    logic [CHAR_W-1:0] char3, char2, char1, char0;
    logic [15:0]       win;

    int total = 0;
    int bad   = 0;
    int n;
    int hits;

    display_scroll_sequencer #(
        .MSG_LEN  (MSG_LEN),
        .TICK_DIV (TICK_DIV),
        .CHAR_W   (CHAR_W)
    ) dut (
        .clk        (clk),
        .reset_sync (reset_sync),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .stop       (stop),
        .busy       (busy),
        .pos        (pos),
        .step_done  (step_done),
        .wrap       (wrap),
        .char3      (char3),
        .char2      (char2),
        .char1      (char1),
        .char0      (char0)
    );

    assign win = {char3, char2, char1, char0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One active edge, then sample on the falling edge.
    task automatic step_clk();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Clock until a step pulse shows up; returns the number of edges taken (99 on timeout).
    task automatic run_to_step(output int cycles);
        cycles = 99;
        for (int i = 1; i <= 10; i++) begin
            step_clk();
            if (step_done) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [CHAR_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step_clk();
        wr_en   = 1'b0;
    endtask

    initial begin
        reset_sync = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pos", 32'(pos), 32'd0);
        chk("rst_win", 32'(win), 32'h0);
        chk("rst_step", 32'(step_done), 32'd0);
        reset_sync = 1'b0;
        step_clk();

        // Load 0..5; frozen window tracks the buffer in IDLE.
        for (int i = 0; i < MSG_LEN; i++) write(AW'(i), CHAR_W'(i));
        step_clk();
        chk("idle_win", 32'(win), 32'h0123);

        // Start and first step.
        start = 1'b1; step_clk(); start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_pos", 32'(pos), 32'd0);
        chk("start_win", 32'(win), 32'h0123);
        run_to_step(n);
        chk("first_step_cadence", 32'(n), 32'd4);
        chk("first_step_pos", 32'(pos), 32'd1);
        chk("first_step_wrap", 32'(wrap), 32'd0);
        step_clk();
        chk("pos1_win", 32'(win), 32'h1234);
        chk("step_pulse_low", 32'(step_done), 32'd0);

        // Advance to pos 5 then wrap.
        run_to_step(n);
        chk("cadence_pos2", 32'(n), 32'd3);
        chk("pos2", 32'(pos), 32'd2);
        for (int p = 3; p <= 5; p++) begin
            run_to_step(n);
            chk("cadence", 32'(n), 32'd4);
            chk("pos_adv", 32'(pos), 32'(p));
        end
        step_clk();
        chk("pos5_win", 32'(win), 32'h5012);
        run_to_step(n);
        chk("wrap_cadence", 32'(n), 32'd3);
        chk("wrap_pos", 32'(pos), 32'd0);
        chk("wrap_pulse", 32'(wrap), 32'd1);
        step_clk();
        chk("wrap_low", 32'(wrap), 32'd0);
        chk("wrap_win", 32'(win), 32'h0123);

        // Stop at pos 3 with cnt 2.
        run_to_step(n); chk("cad_a", 32'(n), 32'd3);
        run_to_step(n); chk("cad_b", 32'(n), 32'd4);
        run_to_step(n); chk("cad_c", 32'(n), 32'd4);
        chk("pre_stop_pos", 32'(pos), 32'd3);
        step_clk(); step_clk();
        stop = 1'b1; step_clk(); stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_pos", 32'(pos), 32'd3);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            step_clk();
            if (step_done || pos != 3'd3) hits++;
        end
        chk("stopped_quiet", 32'(hits), 32'd0);
        chk("stopped_win", 32'(win), 32'h3450);
        start = 1'b1; step_clk(); start = 1'b0;
        chk("restart_pos", 32'(pos), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        run_to_step(n);
        chk("restart_cadence", 32'(n), 32'd4);
        chk("restart_step_pos", 32'(pos), 32'd1);

        // Simultaneous start+stop: in RUN -> IDLE, in IDLE -> stay.
        start = 1'b1; stop = 1'b1; step_clk();
        chk("both_run_busy", 32'(busy), 32'd0);
        chk("both_run_pos", 32'(pos), 32'd1);
        step_clk(); start = 1'b0; stop = 1'b0;
        chk("both_idle_busy", 32'(busy), 32'd0);
        chk("both_idle_pos", 32'(pos), 32'd1);

        // Restart in RUN at pos 4, one edge before a step would fire.
        start = 1'b1; step_clk(); start = 1'b0;
        for (int p = 1; p <= 4; p++) run_to_step(n);
        chk("pos4", 32'(pos), 32'd4);
        step_clk(); step_clk(); step_clk();
        start = 1'b1; step_clk(); start = 1'b0;
        chk("rerun_pos", 32'(pos), 32'd0);
        chk("rerun_step", 32'(step_done), 32'd0);
        chk("rerun_wrap", 32'(wrap), 32'd0);
        chk("rerun_busy", 32'(busy), 32'd1);

        // Write at pos 0, then an out-of-range write.
        write(3'd1, 4'd9);
        chk("wr_lag_win", 32'(win), 32'h0123);
        step_clk();
        chk("wr_win", 32'(win), 32'h0923);
        write(3'd7, 4'hF);
        chk("bad_wr_win", 32'(win), 32'h0923);
        step_clk();
        chk("step_after_wr", 32'(step_done), 32'd1);
        chk("pos_after_wr", 32'(pos), 32'd1);
        step_clk();
        chk("bad_wr_win2", 32'(win), 32'h9234);

        // Asynchronous reset mid-run.
        #2 reset_sync = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_pos", 32'(pos), 32'd0);
        chk("arst_win", 32'(win), 32'h0);
        @(negedge clk);
        reset_sync = 1'b0;
        step_clk();
        chk("post_rst_win", 32'(win), 32'h0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
